// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch stage in front of instmem.
// Owns the program counter, issues synchronous reads to instmem and captures
// the returning words into a 2-entry buffer presented to the decoder with a
// valid/ready handshake. Supports redirect (flush and restart) and halt.
// Optional boot loader that streams a program image into instmem after reset:
// compile with `define INST_FETCH_BOOTLOAD_EN.
`timescale 1ns/1ps
module inst_fetch #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] addIM,
    output logic              we_IM,
    output logic [DATA_W-1:0] dataIM,
    input  logic [DATA_W-1:0] outIM,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt
`ifdef INST_FETCH_BOOTLOAD_EN
    ,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready
`endif
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

`ifdef INST_FETCH_BOOTLOAD_EN
    localparam state_t            ST_RESET   = ST_BOOT;
    localparam logic [ADDR_W-1:0] ADDR_RESET = '0;
`else
    localparam state_t            ST_RESET   = ST_FETCH;
    localparam logic [ADDR_W-1:0] ADDR_RESET = RESET_PC;
`endif

    state_t              r_state;
    state_t              w_next_state;

    logic [ADDR_W-1:0]   r_pc;          // next address to fetch
    logic [ADDR_W-1:0]   r_addr;        // last address presented to instmem
    logic                r_inflight;    // a read response arrives this cycle

    // Buffer head (drives the decoder directly) and second slot.
    logic [DATA_W-1:0]   r_instr;
    logic [ADDR_W-1:0]   r_instr_pc;
    logic                r_valid;
    logic [DATA_W-1:0]   r_tail_instr;
    logic [ADDR_W-1:0]   r_tail_pc;
    logic                r_tail_valid;

    logic                w_fetching;
    logic                w_flush;
    logic                w_pop;
    logic                w_push;
    logic                w_issue;
    logic [1:0]          w_count;
    logic [1:0]          w_occ;

`ifdef INST_FETCH_BOOTLOAD_EN
    logic [ADDR_W-1:0]   r_ld_ptr;
    logic                r_ld_ready;
    logic                w_beat;

    assign w_beat   = (r_state == ST_BOOT) & r_ld_ready & ld_valid;
    assign ld_ready = r_ld_ready;
`endif

    assign w_fetching = (r_state != ST_BOOT);
    assign w_flush    = w_fetching & redirect;
    assign w_pop      = r_valid & instr_ready;
    assign w_push     = r_inflight & ~w_flush;

    // Occupancy after this cycle's pop, counting the response still on its way.
    assign w_count = {1'b0, r_valid} + {1'b0, r_tail_valid};
    assign w_occ   = w_count + {1'b0, r_inflight} - {1'b0, w_pop};
    assign w_issue = w_fetching & ~halt & ~redirect & (w_occ < 2'd2);

    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_valid;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of process evaluation order.
        if (!rst_n) r_state <= ST_RESET;
        else        r_state <= w_next_state;
    end

    // Next-state logic: boot until the last image beat, then follow halt.
    always_comb begin
        // NOTE: a default assignment up front keeps every path covered, so no latch.
        w_next_state = r_state;
        case (r_state)
            ST_BOOT: begin
`ifdef INST_FETCH_BOOTLOAD_EN
                if (w_beat && ld_last) w_next_state = ST_FETCH;
`else
                w_next_state = ST_FETCH;
`endif
            end
            ST_FETCH:  if (halt)  w_next_state = ST_HALTED;
            ST_HALTED: if (!halt) w_next_state = ST_FETCH;
            default:   w_next_state = ST_RESET;
        endcase
    end

    // Memory port: present pc on an issue, the load pointer on a boot beat,
    // otherwise hold the last address.
    always_comb begin
        addIM  = r_addr;
        we_IM  = 1'b0;
        dataIM = '0;
        if (w_issue) addIM = r_pc;
`ifdef INST_FETCH_BOOTLOAD_EN
        if (w_beat) begin
            addIM  = r_ld_ptr;
            we_IM  = 1'b1;
            dataIM = ld_data;
        end
`endif
    end

    // Program counter, last presented address and in-flight flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_addr     <= ADDR_RESET;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_flush) begin
                r_pc <= redirect_pc;
            end else if (w_issue) begin
                r_pc   <= r_pc + ADDR_W'(1);
                r_addr <= r_pc;
            end
`ifdef INST_FETCH_BOOTLOAD_EN
            if (w_beat) begin
                r_addr <= r_ld_ptr;
                if (ld_last) r_pc <= RESET_PC;
            end
`endif
        end
    end

    // Two-entry buffer: redirect flushes, otherwise pop and push may coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data slots are reset as well, because instr/instr_pc
            // are outputs with defined reset values.
            r_instr      <= '0;
            r_instr_pc   <= '0;
            r_valid      <= 1'b0;
            r_tail_instr <= '0;
            r_tail_pc    <= '0;
            r_tail_valid <= 1'b0;
        end else if (w_flush) begin
            r_valid      <= 1'b0;
            r_tail_valid <= 1'b0;
        end else if (w_pop) begin
            if (r_tail_valid) begin
                r_instr      <= r_tail_instr;
                r_instr_pc   <= r_tail_pc;
                r_tail_valid <= w_push;
                if (w_push) begin
                    r_tail_instr <= outIM;
                    r_tail_pc    <= r_addr;
                end
            end else begin
                r_valid <= w_push;
                if (w_push) begin
                    r_instr    <= outIM;
                    r_instr_pc <= r_addr;
                end
            end
        end else if (w_push) begin
            if (!r_valid) begin
                r_instr    <= outIM;
                r_instr_pc <= r_addr;
                r_valid    <= 1'b1;
            end else begin
                r_tail_instr <= outIM;
                r_tail_pc    <= r_addr;
                r_tail_valid <= 1'b1;
            end
        end
    end

`ifdef INST_FETCH_BOOTLOAD_EN
    // Boot loader: ready while booting, write pointer advances per beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ld_ptr   <= '0;
            r_ld_ready <= 1'b0;
        end else begin
            r_ld_ready <= (w_next_state == ST_BOOT);
            if (w_beat) r_ld_ptr <= r_ld_ptr + ADDR_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: instmem model, queue-based reference
// model compared every cycle, directed scenarios plus randomized traffic.
`timescale 1ns/1ps
module tb_inst_fetch;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 1 << ADDR_W;
`ifdef INST_FETCH_BOOTLOAD_EN
    localparam logic [15:0] EXP0 = 16'h0234;
    localparam logic [15:0] EXP1 = 16'h0381;
`else
    localparam logic [15:0] EXP0 = 16'h1000;
    localparam logic [15:0] EXP1 = 16'h1001;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ADDR_W-1:0] addIM;
    logic              we_IM;
    logic [DATA_W-1:0] dataIM;
    logic [DATA_W-1:0] outIM;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready = 1'b0;
    logic              redirect = 1'b0;
    logic [ADDR_W-1:0] redirect_pc = '0;
    logic              halt = 1'b0;
`ifdef INST_FETCH_BOOTLOAD_EN
    logic              ld_valid = 1'b0;
    logic [DATA_W-1:0] ld_data = '0;
    logic              ld_last = 1'b0;
    logic              ld_ready;
`endif

    int n_vec = 0;
    int n_err = 0;

    inst_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC('0)) dut (
        .clk(clk), .rst_n(rst_n),
        .addIM(addIM), .we_IM(we_IM), .dataIM(dataIM), .outIM(outIM),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .redirect(redirect),
        .redirect_pc(redirect_pc), .halt(halt)
`ifdef INST_FETCH_BOOTLOAD_EN
        , .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready)
`endif
    );

    always #5 clk = ~clk;

    // instmem model: synchronous read, write on we_IM.
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ref_mem [DEPTH];
    always @(posedge clk) begin
        outIM <= mem[addIM];
        if (we_IM) mem[addIM] = dataIM;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: addresses awaiting delivery, in order.
    logic [ADDR_W-1:0] m_fifo[$];
    logic [ADDR_W-1:0] m_infl[$];
    logic [ADDR_W-1:0] m_pc;
    logic [ADDR_W-1:0] m_last;
    logic [ADDR_W-1:0] m_addr_exp;
    bit                model_on = 1'b1;
    bit                m_valid, m_pop, m_issue;
    int                m_occ;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_fifo.delete();
            m_infl.delete();
            m_pc   = '0;
            m_last = '0;
`ifdef INST_FETCH_BOOTLOAD_EN
            model_on = 1'b0;
            check("rst_ld_ready", 32'(ld_ready), 0);
`endif
            check("rst_valid", 32'(instr_valid), 0);
            check("rst_addIM", 32'(addIM), 0);
            check("rst_we_IM", 32'(we_IM), 0);
            check("rst_instr", 32'(instr), 0);
            check("rst_instr_pc", 32'(instr_pc), 0);
        end else if (model_on) begin
            m_valid    = (m_fifo.size() != 0);
            m_pop      = m_valid && instr_ready;
            m_occ      = m_fifo.size() + m_infl.size() - int'(m_pop);
            m_issue    = !halt && !redirect && (m_occ < 2);
            m_addr_exp = m_issue ? m_pc : m_last;
            check("instr_valid", 32'(instr_valid), 32'(m_valid));
            check("addIM", 32'(addIM), 32'(m_addr_exp));
            check("we_IM", 32'(we_IM), 0);
            if (m_valid) begin
                check("instr", 32'(instr), 32'(ref_mem[m_fifo[0]]));
                check("instr_pc", 32'(instr_pc), 32'(m_fifo[0]));
            end
            if (redirect) begin
                m_fifo.delete();
                m_infl.delete();
                m_pc = redirect_pc;
            end else begin
                if (m_pop) void'(m_fifo.pop_front());
                if (m_infl.size() != 0) m_fifo.push_back(m_infl.pop_front());
                if (m_issue) begin
                    m_infl.push_back(m_pc);
                    m_last = m_pc;
                    m_pc   = m_pc + 12'd1;
                end
            end
        end
    end

`ifdef INST_FETCH_BOOTLOAD_EN
    task automatic do_boot();
        logic [DATA_W-1:0] img [2];
        img[0] = 16'h0234;
        img[1] = 16'h0381;
        for (int b = 0; b < 2; b++) begin
            int guard;
            guard    = 0;
            ld_valid = 1'b1;
            ld_data  = img[b];
            ld_last  = (b == 1);
            @(negedge clk);
            while (!ld_ready && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            check("boot_ld_ready", 32'(ld_ready), 1);
            check("boot_we_IM", 32'(we_IM), 1);
            check("boot_addIM", 32'(addIM), b);
            check("boot_dataIM", 32'(dataIM), 32'(img[b]));
            ref_mem[b] = img[b];
            @(posedge clk);
            #1;
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        m_fifo.delete();
        m_infl.delete();
        m_pc     = '0;
        m_last   = 12'd1;
        model_on = 1'b1;
    endtask
`endif

    // Release reset (and boot, if built in); first word two cycles later.
    task automatic start_run(input bit rdy);
        instr_ready = rdy;
        halt        = 1'b0;
        redirect    = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
`ifdef INST_FETCH_BOOTLOAD_EN
        do_boot();
`endif
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k < 2) begin
                check("first_gap", 32'(instr_valid), 0);
            end else begin
                check("first_valid", 32'(instr_valid), 1);
                check("first_instr", 32'(instr), 32'(EXP0));
                check("first_pc", 32'(instr_pc), 0);
            end
        end
    endtask

    // Pulse redirect for one cycle; expect a 2-cycle gap then three words.
    task automatic do_redirect(input logic [ADDR_W-1:0] pc, input logic [15:0] e0,
                               input logic [15:0] e1, input logic [15:0] e2);
        logic [ADDR_W-1:0] p;
        logic [15:0] ew [3];
        ew[0] = e0; ew[1] = e1; ew[2] = e2;
        instr_ready = 1'b1;
        @(posedge clk);
        #1 redirect = 1'b1;
        redirect_pc = pc;
        @(posedge clk);
        #1 redirect = 1'b0;
        @(negedge clk);
        check("redir_gap1", 32'(instr_valid), 0);
        @(negedge clk);
        check("redir_gap2", 32'(instr_valid), 0);
        p = pc;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("redir_valid", 32'(instr_valid), 1);
            check("redir_pc", 32'(instr_pc), 32'(p));
            check("redir_instr", 32'(instr), 32'(ew[k]));
            p = p + 12'd1;
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = 16'h1000 + 16'(i);
            ref_mem[i] = 16'h1000 + 16'(i);
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);

        // Decoder stalled from the start: two words buffered, head holds.
        start_run(1'b0);
        repeat (3) @(negedge clk);
        check("stall_head", 32'(instr), 32'(EXP0));
        check("stall_pc", 32'(instr_pc), 0);
        check("stall_addIM", 32'(addIM), 1);
        @(posedge clk);
        #1 instr_ready = 1'b1;
        repeat (8) @(posedge clk);

        // Redirect mid-stream, then across the top of the address space.
        do_redirect(12'h0A0, 16'h10A0, 16'h10A1, 16'h10A2);
        repeat (4) @(posedge clk);
        do_redirect(12'hFFF, 16'h1FFF, EXP0, EXP1);
        repeat (4) @(posedge clk);

        // Halt for four cycles: in-flight word delivered, then the buffer drains.
        #1 halt = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("halt_drained", 32'(instr_valid), 0);
        @(negedge clk);
        check("halt_idle", 32'(instr_valid), 0);
        @(posedge clk);
        #1 halt = 1'b0;
        repeat (6) @(posedge clk);

        // Randomized traffic against the model.
        for (int c = 0; c < 500; c++) begin
            #1;
            instr_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 9) == 0) halt = ~halt;
            redirect    = ($urandom_range(0, 24) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? 12'hFFE : ADDR_W'($urandom_range(0, DEPTH - 1));
            @(posedge clk);
        end
        #1;
        halt        = 1'b0;
        redirect    = 1'b0;
        instr_ready = 1'b1;
        repeat (6) @(posedge clk);

        // Asynchronous reset mid-stream.
        check("pre_rst_valid", 32'(instr_valid), 1);
        #3 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(instr_valid), 0);
        check("arst_instr", 32'(instr), 0);
        check("arst_instr_pc", 32'(instr_pc), 0);
        check("arst_addIM", 32'(addIM), 0);
        check("arst_we_IM", 32'(we_IM), 0);
        repeat (2) @(posedge clk);
        start_run(1'b1);
        repeat (10) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage sitting directly upstream of `instmem`: owns the program counter, drives the instruction memory address/write port, and captures `outIM` into a small tagged buffer presented to the decoder with a valid/ready handshake. It supports PC redirect (branch/jump) with in-flight discard and a halt input. Optionally, it hosts a boot loader that streams a program image into `instmem` after reset, before fetching starts.

## Interface
- `ADDR_W`, 12, instruction memory address width
- `DATA_W`, 16, instruction word width
- `RESET_PC`, 0, first fetch address after reset or boot load
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `addIM`  out  ADDR_W  address to `instmem`
- `we_IM`  out  1  write enable to `instmem`; 0 except during boot load
- `dataIM`  out  DATA_W  write data to `instmem`
- `outIM`  in  DATA_W  `instmem` read data, valid the cycle after `addIM` is presented
- `instr`  out  DATA_W  instruction at buffer head
- `instr_pc`  out  ADDR_W  address of `instr`
- `instr_valid`  out  1  buffer head valid
- `instr_ready`  in  1  decoder accepts the head this cycle
- `redirect`  in  1  one-cycle pulse: flush and restart at `redirect_pc`
- `redirect_pc`  in  ADDR_W  new fetch address
- `halt`  in  1  level: stop issuing new fetches
- `ld_valid`, `ld_data[DATA_W]`, `ld_last`  in; `ld_ready`  out  (present only with `INST_FETCH_BOOTLOAD_EN`)

## Operation
- Reset values: `pc`=RESET_PC, `addIM`=RESET_PC (0 in BOOT), `we_IM`=0, `dataIM`=0, `instr`=0, `instr_pc`=0, `instr_valid`=0, `ld_ready`=0, buffer empty, no fetch in flight.
- States: BOOT (macro only), FETCH, HALTED.
- FETCH: a fetch issues in a cycle when `halt`=0, `redirect`=0, and `count + inflight − pop < 2`.
  - `count` is buffer occupancy.
  - `pop` = `instr_valid & instr_ready`.
  - On issue, `addIM` = `pc`, the in-flight flag is set for the next cycle, and `pc` <= `pc`+1, wrapping 2^ADDR_W−1 -> 0.
- Response: in the cycle after an issue, `outIM` and the issued address are written into a 2-entry FIFO. The head drives `instr`/`instr_pc` registered.
- Handshake: `instr_valid` stays high with stable `instr`/`instr_pc` until `pop`. The FIFO supports a simultaneous push and pop when full.
- `redirect` at cycle t:
  - FIFO cleared.
  - Any response arriving at t+1 is discarded.
  - `pc` <= `redirect_pc`.
  - `redirect` has priority over `halt` and `pop`.
- `halt`=1 moves to HALTED: no issues, but the in-flight response is still captured and the FIFO drains normally. `halt`=0 returns to FETCH and resumes at `pc`.
- `addIM` holds its last value when not issuing. `we_IM` is 0 outside BOOT.

## Timing
- Fetch latency: issue at cycle t, `outIM` at t+1, `instr_valid` at t+2.
- First fetch is in the first cycle after `rst_n` deasserts (FETCH builds), so `instr_valid` first rises two cycles after reset release.
- Sustained throughput: 1 instruction/cycle with `instr_ready`=1.
- Redirect at t: first new issue at t+1, and `instr_valid` for `redirect_pc` at t+3.
- Asynchronous reset mid-operation immediately forces all reset values. In-flight data is lost.

## Configuration
- `INST_FETCH_BOOTLOAD_EN` defined: reset enters BOOT.
  - `ld_ready`=1 in BOOT.
  - Each `ld_valid` beat drives `we_IM`=1, `dataIM`=`ld_data`, `addIM`=load pointer (starting at 0), then increments the pointer.
  - The beat with `ld_last`=1 writes and then moves to FETCH with `pc`=RESET_PC. The first issue occurs in the following cycle.
  - `redirect`/`halt` are ignored in BOOT.
- Undefined: no `ld_*` ports, no BOOT state, and FETCH is entered directly from reset.

## Test plan
- Memory preloaded with 0x1000+i, `instr_ready`=1 -> `instr` 0x1000, 0x1001, 0x1002… with `instr_pc` 0, 1, 2…, one per cycle from 2 cycles after reset.
- `instr_ready`=0 for 5 cycles -> at most 2 entries buffered; head holds 0x1000/pc 0; no address issued beyond 1; ordered resumption with no loss on release.
- `redirect`=1, `redirect_pc`=0x0A0 mid-stream -> stale in-flight word dropped; next `instr_valid` 3 cycles later with `instr_pc`=0x0A0, `instr`=0x10A0.
- `redirect_pc`=0xFFF -> `instr_pc` sequence 0xFFF, 0x000, 0x001 (wrap).
- `halt` asserted 4 cycles -> in-flight word delivered, then `instr_valid` falls; on release, fetch resumes at the next sequential pc; `rst_n` pulsed mid-stream -> all outputs return to reset values immediately.
- With `INST_FETCH_BOOTLOAD_EN`: stream 0x0234, 0x0381 (last) -> `we_IM` pulses at addresses 0, 1; then fetch returns `instr` 0x0234, 0x0381.
